// File: rtl/n4_input_loader.sv
// Frame loader for the LeNet system top: takes a 28x28 8-bit pixel stream, zero-pads it
// to 32x32 in raster order, writes it as 16-bit words into the C1 source buffer, then drops we.
module n4_input_loader #(
    parameter int IMG_W     = 28,
    parameter int PAD       = 2,
    parameter int PIX_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        sys_en,
    output logic        sys_we,
    output logic [31:0] sys_wr_addr,
    output logic [15:0] sys_din,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam int BUF_W = IMG_W + 2 * PAD;
    localparam int CW    = $clog2(BUF_W);
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int PW    = $clog2(NPIX + 1);

    localparam logic [CW-1:0] POS_LO   = CW'(PAD);
    localparam logic [CW-1:0] POS_HI   = CW'(PAD + IMG_W);
    localparam logic [CW-1:0] POS_MAX  = CW'(BUF_W - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FILL,
        TAIL,
        DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   row_reg;
    logic [CW-1:0]   col_reg;
    logic [PW-1:0]   pix_reg;
    logic            trunc_reg;

    logic            in_image;
    logic            step;
    logic            last_pix;
    logic [31:0]     addr_next;
    logic [15:0]     pix_shifted;

    assign in_image    = (row_reg >= POS_LO) && (row_reg < POS_HI) &&
                         (col_reg >= POS_LO) && (col_reg < POS_HI);
    // After an early s_last the rest of the image area is treated like padding.
    assign s_ready     = (state_reg == FILL) && in_image && !trunc_reg;
    assign step        = (state_reg == FILL) && (!s_ready || s_valid);
    assign last_pix    = (pix_reg == LAST_PIX);
    assign addr_next   = 32'(row_reg) * 32'(BUF_W) + 32'(col_reg);
    assign pix_shifted = {8'h00, s_data} << PIX_SHIFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            col_reg     <= '0;
            pix_reg     <= '0;
            trunc_reg   <= 1'b0;
            sys_en      <= 1'b0;
            sys_we      <= 1'b0;
            sys_wr_addr <= '0;
            sys_din     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ARM;
                        busy      <= 1'b1;
                    end
                end
                ARM: begin
                    sys_en    <= 1'b1;
                    sys_we    <= 1'b0;
                    frame_err <= 1'b0;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    pix_reg   <= '0;
                    trunc_reg <= 1'b0;
                    state_reg <= FILL;
                end
                FILL: begin
                    if (step) begin
                        sys_we      <= 1'b1;
                        sys_wr_addr <= addr_next;
                        if (s_ready) begin
                            sys_din <= pix_shifted;
                            pix_reg <= pix_reg + 1'b1;
                            if (s_last && !last_pix) begin
                                frame_err <= 1'b1;
                                trunc_reg <= 1'b1;
                            end
                            if (!s_last && last_pix) begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            sys_din <= '0;
                        end
                        if (col_reg == POS_MAX) begin
                            col_reg <= '0;
                            if (row_reg == POS_MAX) begin
                                state_reg <= TAIL;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end else begin
                        sys_we <= 1'b0;
                    end
                end
                TAIL: begin
                    // Falling edge of we is what launches C1S2 in the top.
                    sys_we    <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= DONE;
                end
                DONE: begin
                    sys_we <= 1'b0;
                    if (start) begin
                        state_reg <= ARM;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
